// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the WFI sleep sequencer.
package cv32e41s_pkg;

    typedef enum logic [1:0] {
        WFI_RUN,
        WFI_DRAIN,
        WFI_SLEEP,
        WFI_WAKE
    } wfi_seq_state_e;

    localparam int unsigned WFI_WAKE_DELAY_MAX = 15;
    localparam int unsigned SLEEP_CNT_W        = 32;

endpackage

// File: rtl/cv32e41s_sleep_cycle_counter.sv
// Saturating sleep-cycle counter; clear wins over increment.
module cv32e41s_sleep_cycle_counter
    import cv32e41s_pkg::*;
(
    input  logic                   clk_ungated_i,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    output logic [SLEEP_CNT_W-1:0] count
);

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cv32e41s_wfi_sequencer.sv
// WFI sleep sequencer: halts fetch, drains IF/LSU, releases busy for clock gating,
// then settles for WAKE_DELAY cycles on wake. Sleep statistics under CV32E41S_SLEEP_STATS_EN.
//   state     | meaning
//   WFI_RUN   | normal execution, fetch enabled
//   WFI_DRAIN | fetch halted, waiting for IF and LSU to go idle
//   WFI_SLEEP | busy dropped, core clock may be gated
//   WFI_WAKE  | clock running again, fetch held for settle delay
module cv32e41s_wfi_sequencer
    import cv32e41s_pkg::*;
#(
    parameter int unsigned WAKE_DELAY = 2
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_n,
    input  logic                   wfi_req_i,
    input  logic                   debug_mode_i,
    input  logic                   irq_pending_i,
    input  logic                   debug_req_i,
    input  logic                   if_busy_i,
    input  logic                   lsu_busy_i,
    input  logic                   stats_clr_i,
    output logic                   halt_if_o,
    output logic                   ctrl_busy_o,
    output logic                   wake_from_sleep_o,
    output logic                   sleep_o,
    output logic                   wfi_done_o,
    output logic [SLEEP_CNT_W-1:0] sleep_cycles_o
);

    generate
        if (WAKE_DELAY > WFI_WAKE_DELAY_MAX) begin : g_bad_wake_delay
            $error("WAKE_DELAY exceeds the 4-bit settle counter range");
        end
    endgenerate

    localparam logic [3:0] WAKE_LAST = (WAKE_DELAY == 0) ? 4'd0 : 4'(WAKE_DELAY - 1);

    wfi_seq_state_e state;
    logic [3:0]     cnt;
    logic           wake_event;

    assign wake_event        = irq_pending_i | debug_req_i;
    assign wake_from_sleep_o = (state == WFI_SLEEP) & wake_event;

    // Outputs are set alongside the state update so they track the next state.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WFI_RUN;
            cnt         <= '0;
            halt_if_o   <= 1'b0;
            ctrl_busy_o <= 1'b1;
            sleep_o     <= 1'b0;
            wfi_done_o  <= 1'b0;
        end else begin
            wfi_done_o <= 1'b0;
            case (state)
                WFI_RUN: begin
                    if (wfi_req_i) begin
                        if (debug_mode_i || wake_event) begin
                            wfi_done_o <= 1'b1;
                        end else begin
                            state     <= WFI_DRAIN;
                            halt_if_o <= 1'b1;
                        end
                    end
                end
                WFI_DRAIN: begin
                    if (wake_event) begin
                        state      <= WFI_RUN;
                        halt_if_o  <= 1'b0;
                        wfi_done_o <= 1'b1;
                    end else if (!if_busy_i && !lsu_busy_i) begin
                        state       <= WFI_SLEEP;
                        ctrl_busy_o <= 1'b0;
                        sleep_o     <= 1'b1;
                    end
                end
                WFI_SLEEP: begin
                    if (wake_event) begin
                        ctrl_busy_o <= 1'b1;
                        sleep_o     <= 1'b0;
                        if (WAKE_DELAY == 0) begin
                            state      <= WFI_RUN;
                            halt_if_o  <= 1'b0;
                            wfi_done_o <= 1'b1;
                        end else begin
                            state <= WFI_WAKE;
                            cnt   <= '0;
                        end
                    end
                end
                WFI_WAKE: begin
                    if (cnt == WAKE_LAST) begin
                        state      <= WFI_RUN;
                        halt_if_o  <= 1'b0;
                        wfi_done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state       <= WFI_RUN;
                    halt_if_o   <= 1'b0;
                    ctrl_busy_o <= 1'b1;
                    sleep_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CV32E41S_SLEEP_STATS_EN
    cv32e41s_sleep_cycle_counter u_sleep_cycle_counter (
        .clk_ungated_i (clk_ungated_i),
        .rst_n         (rst_n),
        .clr           (stats_clr_i),
        .en            (state == WFI_SLEEP),
        .count         (sleep_cycles_o)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign sleep_cycles_o   = '0;
`endif

    // A WFI can only retire while the core is running; anything else is ignored.
    a_wfi_only_in_run: assert property (
        @(posedge clk_ungated_i) disable iff (!rst_n) wfi_req_i |-> (state == WFI_RUN)
    );

endmodule

// File: tb/tb_cv32e41s_wfi_sequencer.sv
// Scoreboard bench: two lanes (WAKE_DELAY 2 and 0) driven by episode-level stimulus.
module tb_cv32e41s_wfi_sequencer;

    typedef enum int {P_RUN, P_DRAIN, P_SLEEP, P_WAKE} phase_t;
    typedef struct {
        logic        halt;
        logic        busy;
        logic        slp;
        logic        wake;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    logic clk_ungated_i = 1'b0;
    logic rst_n = 1'b0;

    logic req[2], irq[2], dbg[2], dbgm[2], ifb[2], lsub[2], clr[2];
    logic halt[2], busy[2], slp[2], wake[2], done[2];
    logic [31:0] scnt[2];

    exp_t        sb[2][$];
    logic        pend_done[2];
    logic [31:0] cnt_m[2];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    always #5 clk_ungated_i = ~clk_ungated_i;

    cv32e41s_wfi_sequencer #(.WAKE_DELAY(2)) dut_d2 (
        .clk_ungated_i     (clk_ungated_i),
        .rst_n             (rst_n),
        .wfi_req_i         (req[0]),
        .debug_mode_i      (dbgm[0]),
        .irq_pending_i     (irq[0]),
        .debug_req_i       (dbg[0]),
        .if_busy_i         (ifb[0]),
        .lsu_busy_i        (lsub[0]),
        .stats_clr_i       (clr[0]),
        .halt_if_o         (halt[0]),
        .ctrl_busy_o       (busy[0]),
        .wake_from_sleep_o (wake[0]),
        .sleep_o           (slp[0]),
        .wfi_done_o        (done[0]),
        .sleep_cycles_o    (scnt[0])
    );

    cv32e41s_wfi_sequencer #(.WAKE_DELAY(0)) dut_d0 (
        .clk_ungated_i     (clk_ungated_i),
        .rst_n             (rst_n),
        .wfi_req_i         (req[1]),
        .debug_mode_i      (dbgm[1]),
        .irq_pending_i     (irq[1]),
        .debug_req_i       (dbg[1]),
        .if_busy_i         (ifb[1]),
        .lsu_busy_i        (lsub[1]),
        .stats_clr_i       (clr[1]),
        .halt_if_o         (halt[1]),
        .ctrl_busy_o       (busy[1]),
        .wake_from_sleep_o (wake[1]),
        .sleep_o           (slp[1]),
        .wfi_done_o        (done[1]),
        .sleep_cycles_o    (scnt[1])
    );

    task automatic chk(string name, int l, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
        end
    endtask

    always @(negedge clk_ungated_i) begin
        if (mon_en) begin
            for (int l = 0; l < 2; l++) begin
                exp_t e;
                if (sb[l].size() > 0) begin
                    e = sb[l].pop_front();
                    chk("halt_if", l, 32'(halt[l]), 32'(e.halt));
                    chk("ctrl_busy", l, 32'(busy[l]), 32'(e.busy));
                    chk("sleep", l, 32'(slp[l]), 32'(e.slp));
                    chk("wake_from_sleep", l, 32'(wake[l]), 32'(e.wake));
                    chk("wfi_done", l, 32'(done[l]), 32'(e.done));
                    chk("sleep_cycles", l, scnt[l], e.cnt);
                end
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int dly(int l);
        return (l == 0) ? 2 : 0;
    endfunction

    // One clock cycle of stimulus for lane l while the sequence is in phase p.
    // fin marks the cycle after which the WFI sequence is complete.
    task automatic emit(int l, phase_t p, bit r, bit i, bit d, bit dm, bit fb, bit lb, bit c, bit fin);
        exp_t e;
        @(posedge clk_ungated_i);
        #1;
        req[l] = r; irq[l] = i; dbg[l] = d; dbgm[l] = dm;
        ifb[l] = fb; lsub[l] = lb; clr[l] = c;
        e.halt = (p != P_RUN);
        e.busy = (p != P_SLEEP);
        e.slp  = (p == P_SLEEP);
        e.wake = (p == P_SLEEP) && (i || d);
        e.done = pend_done[l];
`ifdef CV32E41S_SLEEP_STATS_EN
        e.cnt = cnt_m[l];
`else
        e.cnt = 32'd0;
`endif
        sb[l].push_back(e);
        pend_done[l] = fin;
        if (c) cnt_m[l] = 32'd0;
        else if (p == P_SLEEP && cnt_m[l] != 32'hFFFF_FFFF) cnt_m[l] = cnt_m[l] + 32'd1;
    endtask

    task automatic idle(int l, int n, bit rnd);
        for (int k = 0; k < n; k++)
            emit(l, P_RUN, 0, rnd ? rb() : 1'b0, rnd ? rb() : 1'b0, rnd ? rb() : 1'b0,
                 rnd ? rb() : 1'b0, rnd ? rb() : 1'b0, rnd && ($urandom_range(0, 7) == 0), 0);
    endtask

    // which: 0 = irq pending, 1 = debug request, 2 = debug mode
    task automatic nop(int l, int which);
        emit(l, P_RUN, 1, which == 0, which == 1, which == 2, rb(), rb(), 0, 1);
    endtask

    task automatic full(int l, int n_drain, int n_sleep, bit rnd, int clr_at);
        bit w;
        emit(l, P_RUN, 1, 0, 0, 0, rnd ? rb() : 1'b0, 0, 0, 0);
        for (int k = 0; k < n_drain; k++) begin
            bit bsy = (k < n_drain - 1);
            emit(l, P_DRAIN, 0, 0, 0, rnd ? rb() : 1'b0, bsy && rnd && rb(), bsy, 0, 0);
        end
        for (int j = 0; j < n_sleep; j++) begin
            bit last = (j == n_sleep - 1);
            w = rb();
            emit(l, P_SLEEP, 0, last && !w, last && w, rnd ? rb() : 1'b0, rnd ? rb() : 1'b0,
                 rnd ? rb() : 1'b0, (j == clr_at) || (rnd && ($urandom_range(0, 9) == 0)),
                 last && (dly(l) == 0));
        end
        for (int k = 0; k < dly(l); k++)
            emit(l, P_WAKE, 0, rb(), rb(), rb(), rb(), rb(), rnd && rb(), k == dly(l) - 1);
    endtask

    task automatic abort(int l, int n_pre, bit rnd);
        bit w;
        emit(l, P_RUN, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n_pre; k++) begin
            w = rnd ? rb() : 1'b0;
            emit(l, P_DRAIN, 0, 0, 0, 0, !w, w, 0, 0);
        end
        w = rnd ? rb() : 1'b1;
        emit(l, P_DRAIN, 0, !w, w, 0, rnd ? rb() : 1'b1, rnd ? rb() : 1'b0, 0, 1);
    endtask

    task automatic run_lane(int l);
        idle(l, 2, 0);
        nop(l, 0);
        idle(l, 2, 0);
        nop(l, 2);
        idle(l, 2, 0);
        full(l, 3, 10, 0, -1);
        idle(l, 2, 0);
        abort(l, 1, 0);
        idle(l, 2, 0);
        full(l, 1, 4, 0, 2);
        idle(l, 2, 0);
        repeat (30) begin
            case ($urandom_range(0, 2))
                0: nop(l, int'($urandom_range(0, 2)));
                1: full(l, int'($urandom_range(1, 5)), int'($urandom_range(1, 8)), 1, -1);
                default: abort(l, int'($urandom_range(0, 3)), 1);
            endcase
            idle(l, int'($urandom_range(1, 4)), 1);
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            req[l] = 0; irq[l] = 0; dbg[l] = 0; dbgm[l] = 0;
            ifb[l] = 0; lsub[l] = 0; clr[l] = 0;
            pend_done[l] = 0; cnt_m[l] = 32'd0;
        end
        repeat (3) @(posedge clk_ungated_i);
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("reset_halt_if", l, 32'(halt[l]), 32'd0);
            chk("reset_ctrl_busy", l, 32'(busy[l]), 32'd1);
            chk("reset_sleep", l, 32'(slp[l]), 32'd0);
            chk("reset_wake", l, 32'(wake[l]), 32'd0);
            chk("reset_done", l, 32'(done[l]), 32'd0);
            chk("reset_sleep_cycles", l, scnt[l], 32'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;

        fork
            run_lane(0);
            run_lane(1);
        join

        // Park lane 0 in SLEEP, then reset asynchronously.
        emit(0, P_RUN, 1, 0, 0, 0, 0, 0, 0, 0);
        emit(0, P_DRAIN, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) emit(0, P_SLEEP, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_ungated_i);
        #1;
        mon_en = 1'b0;
        chk("pre_reset_sleep", 0, 32'(slp[0]), 32'd1);
        irq[0] = 1'b1;
        #1;
        chk("pre_reset_wake", 0, 32'(wake[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_halt_if", 0, 32'(halt[0]), 32'd0);
        chk("async_reset_ctrl_busy", 0, 32'(busy[0]), 32'd1);
        chk("async_reset_sleep", 0, 32'(slp[0]), 32'd0);
        chk("async_reset_wake", 0, 32'(wake[0]), 32'd0);
        chk("async_reset_done", 0, 32'(done[0]), 32'd0);
        chk("async_reset_sleep_cycles", 0, scnt[0], 32'd0);
        @(posedge clk_ungated_i);
        #1;
        irq[0] = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk_ungated_i);
        #1;
        chk("post_reset_halt_if", 0, 32'(halt[0]), 32'd0);
        chk("post_reset_ctrl_busy", 0, 32'(busy[0]), 32'd1);
        chk("post_reset_sleep", 0, 32'(slp[0]), 32'd0);
        chk("post_reset_done", 0, 32'(done[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e41s_wfi_sequencer.md
Name: cv32e41s_wfi_sequencer

Overview:
- Sequences WFI-based sleep for the core.
- On a retired WFI it halts fetch and waits for IF and LSU to drain, then drops its busy contribution so the sleep unit can gate the clock.
- On a wake event it re-enables the clock, holds fetch for a programmable settle delay, then resumes.
- Runs on the free-running clock, alongside the sleep unit and ahead of the clock gate.

Parameters:
- WAKE_DELAY, 2, settle cycles spent in WAKE before fetch resumes; legal range 0..15.

Ports:
- clk_ungated_i  in  1  free-running clock.
- rst_n  in  1  asynchronous active-low reset.
- wfi_req_i  in  1  single-cycle pulse: WFI retired in WB.
- debug_mode_i  in  1  core in debug mode; WFI becomes a NOP.
- irq_pending_i  in  1  enabled interrupt pending (level).
- debug_req_i  in  1  external debug request (level).
- if_busy_i  in  1  IF has outstanding transactions.
- lsu_busy_i  in  1  LSU has outstanding transactions.
- stats_clr_i  in  1  clear sleep-cycle counter.
- halt_if_o  out  1  stall instruction fetch.
- ctrl_busy_o  out  1  busy contribution to the sleep unit.
- wake_from_sleep_o  out  1  combinational clock-enable request.
- sleep_o  out  1  state is SLEEP.
- wfi_done_o  out  1  one-cycle pulse: WFI sequence complete.
- sleep_cycles_o  out  32  cycles spent in SLEEP.

Behaviour:
- Reset values:
  - state = RUN.
  - ctrl_busy_o = 1. All other outputs = 0; sleep_cycles_o = 0.
  - Reset mid-sequence returns to RUN from any state.
- wake_event = irq_pending_i | debug_req_i.
- RUN:
  - ctrl_busy_o = 1, halt_if_o = 0.
  - wfi_req_i & (debug_mode_i | wake_event): stay in RUN; wfi_done_o pulses in the next cycle (NOP WFI).
  - wfi_req_i otherwise: go to DRAIN.
- DRAIN:
  - ctrl_busy_o = 1, halt_if_o = 1.
  - wake_event: go to RUN and pulse wfi_done_o. Sleep is not entered. This takes priority over drain completion.
  - Else !if_busy_i & !lsu_busy_i: go to SLEEP.
- SLEEP:
  - ctrl_busy_o = 0, halt_if_o = 1, sleep_o = 1.
  - wake_from_sleep_o = wake_event, combinationally, same cycle.
  - wake_event & WAKE_DELAY > 0: go to WAKE and load cnt = 0.
  - wake_event & WAKE_DELAY == 0: go to RUN and pulse wfi_done_o.
- WAKE:
  - ctrl_busy_o = 1, halt_if_o = 1.
  - cnt increments each cycle; at cnt == WAKE_DELAY-1 go to RUN and pulse wfi_done_o.
  - Total WAKE dwell is exactly WAKE_DELAY cycles.
  - A wake_event deassertion during WAKE is ignored.
- wake_from_sleep_o = 0 in every state except SLEEP.
- wfi_req_i outside RUN is ignored; an assertion flags it.
- Counter widths:
  - cnt is 4 bits.
  - WAKE_DELAY > 15 is rejected by an elaboration-time check.
- wfi_done_o is registered: it is high in the first cycle of RUN after a transition, and in the NOP case.

Optional Feature:
- Macro: CV32E41S_SLEEP_STATS_EN.
- Defined:
  - sleep_cycles_o increments by 1 on every clk_ungated_i cycle spent in SLEEP, saturating at 0xFFFFFFFF.
  - stats_clr_i sets the counter to 0 next cycle and takes priority over increment.
- Undefined:
  - sleep_cycles_o tied to 0; stats_clr_i unused.
  - Ports remain present so the interface is stable.

Decomposition:
- cv32e41s_pkg additions:
  - wfi_seq_state_e enum {WFI_RUN, WFI_DRAIN, WFI_SLEEP, WFI_WAKE}.
  - WFI_WAKE_DELAY_MAX = 15.
  - SLEEP_CNT_W = 32.
- Sub-module cv32e41s_sleep_cycle_counter:
  - 32-bit saturating counter with clear and enable.
  - Instantiated only under the macro.

Test Plan:
- NOP WFI: irq_pending_i = 1 and wfi_req_i pulse in RUN -> no DRAIN; wfi_done_o = 1 the next cycle; halt_if_o stays 0.
- Full sleep:
  - Stimulus: wfi_req_i with lsu_busy_i = 1 for 3 cycles, then irq_pending_i after 10 SLEEP cycles, WAKE_DELAY = 2.
  - Required: DRAIN for 3 cycles; SLEEP with ctrl_busy_o = 0.
  - wake_from_sleep_o = 1 in the same cycle irq_pending_i rises; 2 WAKE cycles.
  - wfi_done_o pulses; sleep_cycles_o = 10 with the macro defined.
- DRAIN abort: debug_req_i rises in the 2nd DRAIN cycle while if_busy_i = 1 -> RUN next cycle; sleep_o never 1; wfi_done_o pulse.
- WAKE_DELAY = 0: wake in SLEEP -> RUN in the next cycle with the wfi_done_o pulse; WAKE never visited.
- Debug-mode WFI: debug_mode_i = 1 with wfi_req_i -> treated as NOP; wfi_done_o = 1 the next cycle.
- Reset and clear:
  - rst_n low in SLEEP -> all outputs at reset values immediately (async); state RUN after release.
  - stats_clr_i in the same cycle as an increment -> sleep_cycles_o = 0.
